// File: rtl/return_stack_pkg.sv
// Shared constants for the return-address stack: sizes agreed between the
// datapath and the stack, and the controller's call/return opcodes.
package return_stack_pkg;

  localparam int RS_DATA_WIDTH = 12;
  localparam int RS_DEPTH      = 8;
  localparam int RS_CNT_WIDTH  = $clog2(RS_DEPTH + 1);

  // Controller opcodes that drive push (CALL) and pop (RET).
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;

  // Decode helpers used by the controller to form push/pop requests.
  function automatic logic rs_is_call(input logic [3:0] opcode);
    return opcode == OP_CALL;
  endfunction

  function automatic logic rs_is_ret(input logic [3:0] opcode);
    return opcode == OP_RET;
  endfunction

endpackage

// File: rtl/return_stack_storage.sv
// DEPTH x DATA_WIDTH register array: one write port, one combinational read
// port. Cleared to zero by the asynchronous reset.
module return_stack_storage #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Entry registers: cleared on reset, written only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_stack.sv
// Return-address stack for the single-cycle core. The datapath pushes pc+1
// on a call and loads top into pc on a return; top is driven from storage
// so it can be loaded on the same edge that performs the pop. Overflow and
// underflow are sticky until reset or flush.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DATA_WIDTH = RS_DATA_WIDTH,
  parameter int DEPTH      = RS_DEPTH,
  parameter int CNT_WIDTH  = RS_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] top,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int             IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  we;
  logic [IDX_W-1:0]      waddr;
  logic [IDX_W-1:0]      top_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  // Top entry sits at count-1; when empty the index is a don't-care and
  // the output is forced to zero below.
  assign top_idx  = IDX_W'(count_q - ONE_C);

  return_stack_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (push_data),
    .raddr_i (top_idx),
    .rdata_o (rd_data)
  );

  // Next-state pointer, flags and storage write request; flush wins over
  // everything, then the push/pop combination decides.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = '0;
    if (flush) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            we      = 1'b1;
            waddr   = IDX_W'(count_q);
            count_d = count_q + ONE_C;
          end
        end
        2'b01: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            count_d = count_q - ONE_C;
          end
        end
        2'b11: begin
          // Replace the top in place; on an empty stack this is a plain push.
          we = 1'b1;
          if (is_empty) begin
            waddr   = '0;
            count_d = ONE_C;
          end else begin
            waddr = top_idx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Pointer and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign top       = is_empty ? '0 : rd_data;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: stimulus queues the hand-computed status
// expected after each edge, and a monitor compares it just after that edge.
module tb_return_stack;
  import return_stack_pkg::*;

  localparam int DW = RS_DATA_WIDTH;
  localparam int D  = RS_DEPTH;
  localparam int CW = RS_CNT_WIDTH;

  typedef struct packed {
    logic [DW-1:0] top;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;
  } status_t;

  typedef struct {
    status_t st;
    string   name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          push, pop, flush;
  logic [DW-1:0] push_data;
  logic [DW-1:0] top;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;

  exp_t    sb_q[$];
  exp_t    mon_e;
  status_t act;
  int      n_checks = 0;
  int      n_fail   = 0;

  return_stack #(
    .DATA_WIDTH (DW),
    .DEPTH      (D),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  assign act = {top, count, empty, full, overflow, underflow};

  function automatic status_t mk(input int t, input int c, input bit o, input bit u);
    status_t s;
    s.top   = DW'(t);
    s.count = CW'(c);
    s.empty = (c == 0);
    s.full  = (c == D);
    s.ovf   = o;
    s.unf   = u;
    return s;
  endfunction

  task automatic check(input status_t exp, input string name);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got top=%h count=%0d empty=%b full=%b ovf=%b unf=%b, expected top=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
               name, act.top, act.count, act.empty, act.full, act.ovf, act.unf,
               exp.top, exp.count, exp.empty, exp.full, exp.ovf, exp.unf);
    end
  endtask

  // Drive one edge's request and queue the status expected after that edge.
  task automatic step(input bit p, input bit q, input bit f, input int data,
                      input int etop, input int ecnt, input bit eovf, input bit eunf,
                      input string name);
    exp_t e;
    @(negedge clk);
    push      = p;
    pop       = q;
    flush     = f;
    push_data = DW'(data);
    e.st   = mk(etop, ecnt, eovf, eunf);
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    push_data = '0;
  endtask

  // Monitor: compare the oldest queued expectation just after each edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e.st, mon_e.name);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    #1 rst = 1'b1;
    #3 check(mk(0, 0, 0, 0), "reset_state");
    repeat (2) @(posedge clk);
    #1 check(mk(0, 0, 0, 0), "reset_held");
    @(negedge clk);
    rst = 1'b0;

    // Basic push / pop ordering.
    step(1, 0, 0, 'h001, 'h001, 1, 0, 0, "push1");
    step(1, 0, 0, 'h002, 'h002, 2, 0, 0, "push2");
    step(1, 0, 0, 'h003, 'h003, 3, 0, 0, "push3");
    step(0, 1, 0, 0,     'h002, 2, 0, 0, "pop1");
    step(0, 1, 0, 0,     'h001, 1, 0, 0, "pop2");
    step(0, 1, 0, 0,     'h000, 0, 0, 0, "pop3_empty");

    // Asynchronous reset with three entries in flight.
    step(1, 0, 0, 'h0AA, 'h0AA, 1, 0, 0, "pre_rst_a");
    step(1, 0, 0, 'h0BB, 'h0BB, 2, 0, 0, "pre_rst_b");
    step(1, 0, 0, 'h0CC, 'h0CC, 3, 0, 0, "pre_rst_c");
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    #1 check(mk(0, 0, 0, 0), "async_rst_midcycle");
    @(negedge clk);
    rst = 1'b0;

    // Fill, overflow, pop under sticky overflow.
    for (int i = 0; i < D; i++)
      step(1, 0, 0, 'h100 + i, 'h100 + i, i + 1, 0, 0, $sformatf("fill_%0d", i));
    step(1, 0, 0, 'hABC, 'h107, 8, 1, 0, "push_when_full");
    step(0, 1, 0, 0,     'h106, 7, 1, 0, "pop_after_ovf");
    step(0, 0, 1, 0,     'h000, 0, 0, 0, "flush_clears_ovf");

    // Underflow, push while underflow set, flush.
    step(0, 1, 0, 0,     'h000, 0, 0, 1, "pop_when_empty");
    step(1, 0, 0, 'h055, 'h055, 1, 0, 1, "push_after_unf");
    step(0, 0, 1, 0,     'h000, 0, 0, 0, "flush_clears_unf");

    // Simultaneous push + pop: empty, two entries, then full.
    step(1, 1, 0, 'h0FF, 'h0FF, 1, 0, 0, "pushpop_empty");
    step(1, 0, 0, 'h020, 'h020, 2, 0, 0, "push_020");
    step(1, 1, 0, 'h0FF, 'h0FF, 2, 0, 0, "pushpop_two");
    step(0, 1, 0, 0,     'h0FF, 1, 0, 0, "pop_below_replaced");
    step(0, 1, 0, 0,     'h000, 0, 0, 0, "pop_to_empty");
    for (int i = 0; i < D; i++)
      step(1, 0, 0, 'h200 + i, 'h200 + i, i + 1, 0, 0, $sformatf("fill2_%0d", i));
    step(1, 1, 0, 'h0FF, 'h0FF, 8, 0, 0, "pushpop_full");
    step(0, 1, 0, 0,     'h206, 7, 0, 0, "pop_after_pushpop_full");

    // Flush priority over a simultaneous push.
    step(0, 0, 1, 0, 'h000, 0, 0, 0, "flush_pre");
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 'h300 + i, 'h300 + i, i + 1, 0, 0, $sformatf("fill5_%0d", i));
    step(1, 0, 1, 'h3AA, 'h000, 0, 0, 0, "flush_with_push");
    step(1, 0, 0, 'h3BB, 'h3BB, 1, 0, 0, "push_after_flush");
    step(0, 0, 0, 0,     'h3BB, 1, 0, 0, "idle_hold");

    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
